// File: rtl/conv1d_pkg.sv
// Shared definitions for the Conv1D access controller: state encoding,
// L0 status codes, the registered strobe bundle and small helpers.
package conv1d_pkg;

    // Controller states (4-bit, kept as plain constants for legacy tools)
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD_W  = 4'd1;
    localparam logic [3:0] S_LOAD_I  = 4'd2;
    localparam logic [3:0] S_LOAD_O  = 4'd3;
    localparam logic [3:0] S_PREP    = 4'd4;
    localparam logic [3:0] S_FILL    = 4'd5;
    localparam logic [3:0] S_COMPUTE = 4'd6;
    localparam logic [3:0] S_DRAIN   = 4'd7;
    localparam logic [3:0] S_WPREP   = 4'd8;
    localparam logic [3:0] S_WRITE   = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    // L0 buffer status codes seen by the index generator
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADV  = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

    // Every strobe the controller drives, registered as one bundle
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       mem_w_rst;
        logic       mem_i_rst;
        logic       mem_o_rst;
        logic       l0_w_rst;
        logic       l0_i_rst;
        logic       l0_o_rst;
        logic [1:0] l0_w_st;
        logic [1:0] l0_i_st;
        logic [1:0] l0_o_st;
        logic       data_ready;
        logic       w_load;
        logic       i_load;
        logic       o_load;
        logic       o_write;
    } ctrl_out_t;

    // Smallest r with 2**r >= value (0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Strobe decode for a given state; first_fill marks the opening FILL
    // cycle and first_wt marks weight tile 0 of the current output tile.
    function automatic ctrl_out_t decode_outputs(input logic [3:0] state,
                                                 input logic       first_fill,
                                                 input logic       first_wt);
        ctrl_out_t o;
        o = '0;
        case (state)
            S_IDLE: begin
                o.mem_w_rst = 1'b1;
                o.mem_i_rst = 1'b1;
                o.mem_o_rst = 1'b1;
                o.l0_w_rst  = 1'b1;
                o.l0_i_rst  = 1'b1;
                o.l0_o_rst  = 1'b1;
            end
            S_LOAD_W: begin
                o.busy      = 1'b1;
                o.w_load    = 1'b1;
                o.mem_i_rst = 1'b1;
                o.mem_o_rst = 1'b1;
            end
            S_LOAD_I: begin
                o.busy      = 1'b1;
                o.i_load    = 1'b1;
                o.mem_w_rst = 1'b1;
                o.mem_o_rst = 1'b1;
            end
            S_LOAD_O: begin
                o.busy      = 1'b1;
                o.o_load    = 1'b1;
                o.mem_w_rst = 1'b1;
                o.mem_i_rst = 1'b1;
            end
            S_PREP: begin
                o.busy      = 1'b1;
                o.mem_w_rst = 1'b1;
                o.mem_i_rst = 1'b1;
                o.mem_o_rst = 1'b1;
                o.l0_w_rst  = 1'b1;
                o.l0_i_rst  = 1'b1;
                o.l0_o_rst  = 1'b1;
            end
            S_FILL: begin
                o.busy      = 1'b1;
                o.l0_w_st   = ST_ADV;
                o.l0_i_st   = ST_ADV;
                o.l0_o_st   = ST_IDLE;
                o.mem_w_rst = first_fill & first_wt;
                o.l0_w_rst  = first_fill;
                o.l0_i_rst  = first_fill;
                o.l0_o_rst  = first_fill & first_wt;
            end
            S_COMPUTE: begin
                o.busy       = 1'b1;
                o.l0_w_st    = ST_FULL;
                o.l0_i_st    = ST_FULL;
                o.l0_o_st    = ST_FULL;
                o.data_ready = 1'b1;
            end
            S_DRAIN: begin
                o.busy    = 1'b1;
                o.l0_o_st = ST_ADV;
            end
            S_WPREP: begin
                o.busy      = 1'b1;
                o.mem_o_rst = 1'b1;
            end
            S_WRITE: begin
                o.busy    = 1'b1;
                o.o_write = 1'b1;
            end
            S_DONE: begin
                o.busy      = 1'b1;
                o.done      = 1'b1;
                o.mem_w_rst = 1'b1;
                o.mem_i_rst = 1'b1;
                o.mem_o_rst = 1'b1;
            end
            default: begin
                // Unknown encoding: present the quiescent idle pattern
                o.mem_w_rst = 1'b1;
                o.mem_i_rst = 1'b1;
                o.mem_o_rst = 1'b1;
                o.l0_w_rst  = 1'b1;
                o.l0_i_rst  = 1'b1;
                o.l0_o_rst  = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/conv1d_access_controller_if.sv
// Control bundle between the access controller (master) and the
// memory/L0 index generator plus run requester (slave side).
interface conv1d_access_controller_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       Mem_Weight_Index_Reset;
    logic       Mem_Input_Index_Reset;
    logic       Mem_Output_Index_Reset;
    logic       L0_Weight_Index_Reset;
    logic       L0_Input_Index_Reset;
    logic       L0_Output_Index_Reset;
    logic [1:0] L0_Weight_Status;
    logic [1:0] L0_Input_Status;
    logic [1:0] L0_Output_Status;
    logic       L0_Data_Is_Ready;
    logic       Weight_Loading_From_File;
    logic       Input_Loading_From_File;
    logic       Output_Loading_From_File;
    logic       Output_Writing_To_File;

    modport master (
        input  start,
        output busy, done,
        output Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset,
        output L0_Weight_Index_Reset, L0_Input_Index_Reset, L0_Output_Index_Reset,
        output L0_Weight_Status, L0_Input_Status, L0_Output_Status,
        output L0_Data_Is_Ready,
        output Weight_Loading_From_File, Input_Loading_From_File,
        output Output_Loading_From_File, Output_Writing_To_File
    );

    modport slave (
        output start,
        input  busy, done,
        input  Mem_Weight_Index_Reset, Mem_Input_Index_Reset, Mem_Output_Index_Reset,
        input  L0_Weight_Index_Reset, L0_Input_Index_Reset, L0_Output_Index_Reset,
        input  L0_Weight_Status, L0_Input_Status, L0_Output_Status,
        input  L0_Data_Is_Ready,
        input  Weight_Loading_From_File, Input_Loading_From_File,
        input  Output_Loading_From_File, Output_Writing_To_File
    );
endinterface

// File: rtl/conv1d_access_controller_phase_counter.sv
// Terminal-count counter: advances when enabled, clears on request
// (clear wins), flags when the current count equals the loaded terminal.
// The next-state value is exported so callers can build registered
// outputs that line up with the counter's own register.
module phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over advance
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign last_o     = (cnt_q == term_i);

endmodule

// File: rtl/conv1d_access_controller.sv
// Conv1D access sequencer: load weights/inputs/outputs, walk output and
// weight tiles through L0 fill/compute/drain, then write back. All
// strobes are decoded from the next state and registered.
module conv1d_access_controller
    import conv1d_pkg::*;
#(
    parameter int Weight_Nums    = 4,
    parameter int Input_Nums     = 5,
    parameter int Output_Nums    = 8,
    parameter int L0_Weight_Nums = 2,
    parameter int L0_Input_Nums  = 8,
    parameter int L0_Output_Nums = 8
) (
    input logic                        clk,
    input logic                        rst,
    conv1d_access_controller_if.master ctrl
);

    localparam int COMPUTE_CYCLES = L0_Weight_Nums * L0_Output_Nums;
    localparam int MAX_DWELL = max_int(max_int(max_int(Weight_Nums, Input_Nums),
                                               max_int(Output_Nums, L0_Input_Nums)),
                                       max_int(COMPUTE_CYCLES, L0_Output_Nums));
    localparam int PH_W = clog2(MAX_DWELL) + 1;
    localparam int N_WT = Weight_Nums / L0_Weight_Nums;
    localparam int N_OT = Output_Nums / L0_Output_Nums;
    localparam int WT_W = clog2(N_WT) + 1;
    localparam int OT_W = clog2(N_OT) + 1;

    generate
        if ((Weight_Nums % L0_Weight_Nums) != 0) begin : g_bad_weight_tile
            $error("L0_Weight_Nums must divide Weight_Nums");
        end
        if ((Output_Nums % L0_Output_Nums) != 0) begin : g_bad_output_tile
            $error("L0_Output_Nums must divide Output_Nums");
        end
    endgenerate

    logic [3:0]      state_q;
    logic [3:0]      state_d;
    logic [PH_W-1:0] ph_term_s;
    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;
    logic            ph_last_s;
    logic [WT_W-1:0] wt_q;
    logic [WT_W-1:0] wt_d;
    logic            wt_last_s;
    logic            wt_en_s;
    logic            wt_clr_s;
    logic [OT_W-1:0] ot_q;
    logic [OT_W-1:0] ot_d;
    logic            ot_last_s;
    logic            ot_en_s;
    logic            ot_clr_s;
    logic            first_fill_s;
    logic            first_wt_s;
    ctrl_out_t       out_d;
    ctrl_out_t       out_q;
    logic            tile_unused_s;

    // Dwell length minus one for the current state (0 for single-cycle states)
    always_comb begin
        ph_term_s = {PH_W{1'b0}};
        case (state_q)
            S_LOAD_W:  ph_term_s = PH_W'(Weight_Nums - 1);
            S_LOAD_I:  ph_term_s = PH_W'(Input_Nums - 1);
            S_LOAD_O:  ph_term_s = PH_W'(Output_Nums - 1);
            S_FILL:    ph_term_s = PH_W'(L0_Input_Nums - 1);
            S_COMPUTE: ph_term_s = PH_W'(COMPUTE_CYCLES - 1);
            S_DRAIN:   ph_term_s = PH_W'(L0_Output_Nums - 1);
            S_WRITE:   ph_term_s = PH_W'(Output_Nums - 1);
            default:   ph_term_s = {PH_W{1'b0}};
        endcase
    end

    // Every state leaves when its dwell expires, so clearing on the last
    // count is the same as clearing on each transition; in IDLE the
    // terminal is 0 and the counter is held at zero.
    phase_counter #(.W(PH_W)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (ph_last_s),
        .en_i       (1'b1),
        .term_i     (ph_term_s),
        .cnt_o      (ph_q),
        .cnt_next_o (ph_d),
        .last_o     (ph_last_s)
    );

    assign wt_en_s  = (state_q == S_COMPUTE) && ph_last_s;
    assign wt_clr_s = wt_en_s && wt_last_s;

    phase_counter #(.W(WT_W)) u_weight_tile (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (wt_clr_s),
        .en_i       (wt_en_s),
        .term_i     (WT_W'(N_WT - 1)),
        .cnt_o      (wt_q),
        .cnt_next_o (wt_d),
        .last_o     (wt_last_s)
    );

    assign ot_en_s  = (state_q == S_DRAIN) && ph_last_s;
    assign ot_clr_s = ot_en_s && ot_last_s;

    phase_counter #(.W(OT_W)) u_output_tile (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (ot_clr_s),
        .en_i       (ot_en_s),
        .term_i     (OT_W'(N_OT - 1)),
        .cnt_o      (ot_q),
        .cnt_next_o (ot_d),
        .last_o     (ot_last_s)
    );

    // Only the tile-end flags and next counts feed the decode
    assign tile_unused_s = ^{ph_q, wt_q, ot_q, ot_d};

    // Next-state sequencing through load, tile loops and write-back
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl.start) state_d = S_LOAD_W;
                else            state_d = S_IDLE;
            end
            S_LOAD_W: begin
                if (ph_last_s) state_d = S_LOAD_I;
                else           state_d = S_LOAD_W;
            end
            S_LOAD_I: begin
                if (ph_last_s) state_d = S_LOAD_O;
                else           state_d = S_LOAD_I;
            end
            S_LOAD_O: begin
                if (ph_last_s) state_d = S_PREP;
                else           state_d = S_LOAD_O;
            end
            S_PREP: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                if (ph_last_s) state_d = S_COMPUTE;
                else           state_d = S_FILL;
            end
            S_COMPUTE: begin
                if (ph_last_s) begin
                    if (wt_last_s) state_d = S_DRAIN;
                    else           state_d = S_FILL;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_DRAIN: begin
                if (ph_last_s) begin
                    if (ot_last_s) state_d = S_WPREP;
                    else           state_d = S_FILL;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_WPREP: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (ph_last_s) state_d = S_DONE;
                else           state_d = S_WRITE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode from next state/counters so the registered strobes line up
    // with the state register
    assign first_fill_s = (state_d == S_FILL) && (ph_d == {PH_W{1'b0}});
    assign first_wt_s   = (wt_d == {WT_W{1'b0}});
    assign out_d        = decode_outputs(state_d, first_fill_s, first_wt_s);

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= decode_outputs(S_IDLE, 1'b0, 1'b0);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign ctrl.busy                     = out_q.busy;
    assign ctrl.done                     = out_q.done;
    assign ctrl.Mem_Weight_Index_Reset   = out_q.mem_w_rst;
    assign ctrl.Mem_Input_Index_Reset    = out_q.mem_i_rst;
    assign ctrl.Mem_Output_Index_Reset   = out_q.mem_o_rst;
    assign ctrl.L0_Weight_Index_Reset    = out_q.l0_w_rst;
    assign ctrl.L0_Input_Index_Reset     = out_q.l0_i_rst;
    assign ctrl.L0_Output_Index_Reset    = out_q.l0_o_rst;
    assign ctrl.L0_Weight_Status         = out_q.l0_w_st;
    assign ctrl.L0_Input_Status          = out_q.l0_i_st;
    assign ctrl.L0_Output_Status         = out_q.l0_o_st;
    assign ctrl.L0_Data_Is_Ready         = out_q.data_ready;
    assign ctrl.Weight_Loading_From_File = out_q.w_load;
    assign ctrl.Input_Loading_From_File  = out_q.i_load;
    assign ctrl.Output_Loading_From_File = out_q.o_load;
    assign ctrl.Output_Writing_To_File   = out_q.o_write;

endmodule

// File: tb/tb_conv1d_access_controller.sv
// Bench for conv1d_access_controller: a per-cycle scoreboard built from
// the tile loop structure, a table of cycle-specific strobe checks, and
// hand-written reset/held-start sequences.
module tb_conv1d_access_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv1d_access_controller_if bus_a ();
    conv1d_access_controller_if bus_b ();

    conv1d_access_controller #(
        .Weight_Nums(4), .Input_Nums(5), .Output_Nums(8),
        .L0_Weight_Nums(2), .L0_Input_Nums(8), .L0_Output_Nums(8)
    ) dut_a (.clk(clk), .rst(rst), .ctrl(bus_a));

    conv1d_access_controller #(
        .Weight_Nums(8), .Input_Nums(5), .Output_Nums(16),
        .L0_Weight_Nums(2), .L0_Input_Nums(8), .L0_Output_Nums(8)
    ) dut_b (.clk(clk), .rst(rst), .ctrl(bus_b));

    // Observation vector bit positions
    localparam int B_BUSY = 18, B_DONE = 17, B_MWR = 16, B_MIR = 15, B_MOR = 14;
    localparam int B_LWR = 13, B_LIR = 12, B_LOR = 11, B_RDY = 4;
    localparam int B_WL = 3, B_IL = 2, B_OL = 1, B_OW = 0;

    localparam int T_IDLE = 0, T_LW = 1, T_LI = 2, T_LO = 3, T_PREP = 4, T_FILL = 5;
    localparam int T_COMP = 6, T_DRAIN = 7, T_WPREP = 8, T_WR = 9, T_DONE = 10;

    logic [18:0] obs_a, obs_b;
    assign obs_a = {bus_a.busy, bus_a.done, bus_a.Mem_Weight_Index_Reset,
                    bus_a.Mem_Input_Index_Reset, bus_a.Mem_Output_Index_Reset,
                    bus_a.L0_Weight_Index_Reset, bus_a.L0_Input_Index_Reset,
                    bus_a.L0_Output_Index_Reset, bus_a.L0_Weight_Status,
                    bus_a.L0_Input_Status, bus_a.L0_Output_Status, bus_a.L0_Data_Is_Ready,
                    bus_a.Weight_Loading_From_File, bus_a.Input_Loading_From_File,
                    bus_a.Output_Loading_From_File, bus_a.Output_Writing_To_File};
    assign obs_b = {bus_b.busy, bus_b.done, bus_b.Mem_Weight_Index_Reset,
                    bus_b.Mem_Input_Index_Reset, bus_b.Mem_Output_Index_Reset,
                    bus_b.L0_Weight_Index_Reset, bus_b.L0_Input_Index_Reset,
                    bus_b.L0_Output_Index_Reset, bus_b.L0_Weight_Status,
                    bus_b.L0_Input_Status, bus_b.L0_Output_Status, bus_b.L0_Data_Is_Ready,
                    bus_b.Weight_Loading_From_File, bus_b.Input_Loading_From_File,
                    bus_b.Output_Loading_From_File, bus_b.Output_Writing_To_File};

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [18:0] exp_q[$];
    logic [18:0] tr[0:511];

    typedef struct {
        int    cyc;
        int    bitpos;
        logic  expv;
        string name;
    } tvec_t;
    tvec_t tv[0:21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Expected strobe vector for one cycle in a given state
    function automatic logic [18:0] mk(input int st, input bit ff, input bit wt0);
        logic [18:0] v;
        v = '0;
        v[B_BUSY] = (st != T_IDLE);
        v[B_DONE] = (st == T_DONE);
        v[B_MWR]  = (st == T_IDLE) || (st == T_LI) || (st == T_LO) || (st == T_PREP) ||
                    (st == T_DONE) || ((st == T_FILL) && ff && wt0);
        v[B_MIR]  = (st == T_IDLE) || (st == T_LW) || (st == T_LO) || (st == T_PREP) ||
                    (st == T_DONE);
        v[B_MOR]  = (st == T_IDLE) || (st == T_LW) || (st == T_LI) || (st == T_PREP) ||
                    (st == T_WPREP) || (st == T_DONE);
        v[B_LWR]  = (st == T_IDLE) || (st == T_PREP) || ((st == T_FILL) && ff);
        v[B_LIR]  = v[B_LWR];
        v[B_LOR]  = (st == T_IDLE) || (st == T_PREP) || ((st == T_FILL) && ff && wt0);
        if (st == T_FILL)  v[10:7] = 4'b0101;
        if (st == T_COMP)  begin v[10:5] = 6'b101010; v[B_RDY] = 1'b1; end
        if (st == T_DRAIN) v[6:5] = 2'b01;
        v[B_WL] = (st == T_LW);
        v[B_IL] = (st == T_LI);
        v[B_OL] = (st == T_LO);
        v[B_OW] = (st == T_WR);
        return v;
    endfunction

    // Push the expected per-cycle trace of one run plus the trailing IDLE cycle
    task automatic gen_run(input int wn, input int inn, input int on,
                           input int l0w, input int l0i, input int l0o);
        repeat (wn)  exp_q.push_back(mk(T_LW, 0, 0));
        repeat (inn) exp_q.push_back(mk(T_LI, 0, 0));
        repeat (on)  exp_q.push_back(mk(T_LO, 0, 0));
        exp_q.push_back(mk(T_PREP, 0, 0));
        for (int ot = 0; ot < on / l0o; ot++) begin
            for (int wt = 0; wt < wn / l0w; wt++) begin
                for (int c = 0; c < l0i; c++) exp_q.push_back(mk(T_FILL, c == 0, wt == 0));
                repeat (l0w * l0o) exp_q.push_back(mk(T_COMP, 0, 0));
            end
            repeat (l0o) exp_q.push_back(mk(T_DRAIN, 0, 0));
        end
        exp_q.push_back(mk(T_WPREP, 0, 0));
        repeat (on) exp_q.push_back(mk(T_WR, 0, 0));
        exp_q.push_back(mk(T_DONE, 0, 0));
        exp_q.push_back(mk(T_IDLE, 0, 0));
    endtask

    // Compare n cycles against the scoreboard, recording the trace by cycle number
    task automatic sb_run(input bit use_b, input int n);
        logic [18:0] got;
        logic [18:0] e;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            got = use_b ? obs_b : obs_a;
            tr[i] = got;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("sb_cycle%0d", i), 32'(got), 32'(e));
            end
        end
    endtask

    // One-cycle start pulse sampled at edge E0
    task automatic launch(input bit use_b);
        @(negedge clk);
        if (use_b) bus_b.start = 1'b1;
        else       bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    function automatic int count_bit(input int from, input int to, input int b);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (tr[c][b]) n++;
        return n;
    endfunction

    initial begin
        int n;
        int bad;
        tv[0]  = '{1,  B_WL,   1'b1, "wload_c1"};
        tv[1]  = '{4,  B_WL,   1'b1, "wload_c4"};
        tv[2]  = '{5,  B_WL,   1'b0, "wload_c5"};
        tv[3]  = '{5,  B_IL,   1'b1, "iload_c5"};
        tv[4]  = '{9,  B_IL,   1'b1, "iload_c9"};
        tv[5]  = '{10, B_IL,   1'b0, "iload_c10"};
        tv[6]  = '{10, B_OL,   1'b1, "oload_c10"};
        tv[7]  = '{17, B_OL,   1'b1, "oload_c17"};
        tv[8]  = '{18, B_OL,   1'b0, "oload_c18"};
        tv[9]  = '{1,  B_BUSY, 1'b1, "busy_c1"};
        tv[10] = '{84, B_BUSY, 1'b1, "busy_c84"};
        tv[11] = '{85, B_BUSY, 1'b0, "busy_c85"};
        tv[12] = '{83, B_DONE, 1'b0, "done_c83"};
        tv[13] = '{84, B_DONE, 1'b1, "done_c84"};
        tv[14] = '{18, B_LWR,  1'b1, "l0w_rst_c18"};
        tv[15] = '{19, B_LWR,  1'b1, "l0w_rst_c19"};
        tv[16] = '{20, B_LWR,  1'b0, "l0w_rst_c20"};
        tv[17] = '{43, B_LWR,  1'b1, "l0w_rst_c43"};
        tv[18] = '{43, B_LOR,  1'b0, "l0o_rst_c43"};
        tv[19] = '{43, B_MWR,  1'b0, "memw_rst_c43"};
        tv[20] = '{75, B_MOR,  1'b1, "memo_rst_c75"};
        tv[21] = '{76, B_OW,   1'b1, "owrite_c76"};

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 32'(obs_a), 32'(mk(T_IDLE, 0, 0)));
        chk("reset_b", 32'(obs_b), 32'(mk(T_IDLE, 0, 0)));
        @(negedge clk);
        rst = 1'b0;

        // Default configuration, full run
        gen_run(4, 5, 8, 2, 8, 8);
        n = exp_q.size();
        launch(1'b0);
        sb_run(1'b0, n);
        for (int i = 0; i <= 21; i++)
            chk(tv[i].name, 32'(tr[tv[i].cyc][tv[i].bitpos]), 32'(tv[i].expv));
        chk("ready_count", 32'(count_bit(1, 85, B_RDY)), 32'd32);
        bad = 0;
        for (int c = 1; c <= 85; c++)
            if (tr[c][B_RDY] && (tr[c][10:5] != 6'b101010)) bad++;
        chk("compute_status", 32'(bad), 32'd0);
        bad = 0;
        for (int c = 1; c <= 85; c++) if (tr[c][6:5] == 2'b01) bad++;
        chk("drain_count", 32'(bad), 32'd8);
        chk("memw_rst_loadw", 32'(count_bit(1, 4, B_MWR)), 32'd0);
        chk("done_count", 32'(count_bit(1, 85, B_DONE)), 32'd1);
        chk("busy_count", 32'(count_bit(1, 85, B_BUSY)), 32'd84);

        // Larger configuration: 4 weight tiles, 2 output tiles
        gen_run(8, 5, 16, 2, 8, 8);
        n = exp_q.size();
        launch(1'b1);
        sb_run(1'b1, n);
        chk("b_done_c256", 32'(tr[256][B_DONE]), 32'd1);
        chk("b_done_count", 32'(count_bit(1, 257, B_DONE)), 32'd1);
        chk("b_ready_count", 32'(count_bit(1, 257, B_RDY)), 32'd128);

        // Reset during COMPUTE, then restart
        gen_run(4, 5, 8, 2, 8, 8);
        launch(1'b0);
        sb_run(1'b0, 30);
        chk("c30_in_compute", 32'(tr[30][B_RDY]), 32'd1);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_c31_idle", 32'(obs_a), 32'(mk(T_IDLE, 0, 0)));
        gen_run(4, 5, 8, 2, 8, 8);
        n = exp_q.size();
        launch(1'b0);
        sb_run(1'b0, n);
        chk("restart_c33_loadw", 32'(tr[1][B_WL]), 32'd1);

        // start held high across two runs
        gen_run(4, 5, 8, 2, 8, 8);
        gen_run(4, 5, 8, 2, 8, 8);
        n = exp_q.size();
        @(negedge clk);
        bus_a.start = 1'b1;
        sb_run(1'b0, n);
        bus_a.start = 1'b0;
        chk("held_done_count", 32'(count_bit(1, n, B_DONE)), 32'd2);
        chk("held_idle_c85", 32'(tr[85][B_BUSY]), 32'd0);
        chk("held_run2_c86", 32'(tr[86][B_WL]), 32'd1);
        @(negedge clk);
        chk("held_stop_idle", 32'(obs_a), 32'(mk(T_IDLE, 0, 0)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
